// File: rtl/stacker_pkg.sv
// Shared types and helpers for the block stacker row controller.
// Widths are carried in a 6-bit type so COLS up to 32 fits.
package stacker_pkg;

   localparam int COLS_DEF = 8;
   localparam int ROWS_DEF = 15;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SPAWN,
      S_MOVE,
      S_LOCK,
      S_OVER,
      S_WON
   } state_t;

   typedef enum logic {
      DIR_RIGHT,
      DIR_LEFT
   } dir_t;

   typedef logic [5:0] width_t;

   function automatic width_t clamp_width(input logic [3:0] nb,
                                          input int cols);
      width_t w;
      if (nb == 4'd0)
         w = width_t'(1);
      else if (int'(nb) > cols)
         w = width_t'(cols);
      else
         w = width_t'(nb);
      return w;
   endfunction

   function automatic width_t popcount(input logic [31:0] m);
      width_t c;
      c = '0;
      for (int i = 0; i < 32; i++)
         c = c + width_t'(m[i]);
      return c;
   endfunction

endpackage

// File: rtl/stack_row_controller_if.sv
// Player/board-side bundle of the row controller.
// The controller takes the slave view; the stimulus side takes master.
interface stack_row_controller_if #(
   parameter int COLS = 8
);
   logic            go;
   logic            drop;
   logic [3:0]      level;
   logic [3:0]      num_blocks;
   logic [COLS-1:0] row_mask;
   logic [COLS-1:0] stack_mask;
   logic [3:0]      row_index;
   logic            next_signal;
   logic            game_over;
   logic            win;
   logic            busy;

   modport master (
      output go, drop, level, num_blocks,
      input  row_mask, stack_mask, row_index,
      input  next_signal, game_over, win, busy
   );

   modport slave (
      input  go, drop, level, num_blocks,
      output row_mask, stack_mask, row_index,
      output next_signal, game_over, win, busy
   );
endinterface

// File: rtl/tick_divider.sv
// Programmable shift-rate divider: period latched on load,
// tick when the count reaches period-1 while enabled.
module tick_divider (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        load,
   input  logic        en,
   input  logic [31:0] period_in,
   output logic        tick
);

   logic [31:0] period_q, period_d;
   logic [31:0] cnt_q, cnt_d;

   assign tick = en && (cnt_q == period_q - 32'd1);

   always_comb begin
      period_d = period_q;
      cnt_d    = cnt_q;
      if (load)
         period_d = period_in;
      if (clear)
         cnt_d = '0;
      else if (en)
         cnt_d = tick ? '0 : cnt_q + 32'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         period_q <= 32'd2;
         cnt_q    <= '0;
      end else begin
         period_q <= period_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/stack_row_controller.sv
// One game of the block stacker: spawn, bounce, lock and trim rows,
// reporting placed / missed / won as single-cycle pulses.
module stack_row_controller
   import stacker_pkg::*;
#(
   parameter int          COLS        = COLS_DEF,
   parameter int          ROWS        = ROWS_DEF,
   parameter int unsigned BASE_PERIOD = 25000000,
   parameter int unsigned PERIOD_STEP = 1500000
) (
   input  logic                    clk,
   input  logic                    reset,
   stack_row_controller_if.slave   bus
);

   state_t          state_q, state_d;
   dir_t            dir_q, dir_d;
   logic [COLS-1:0] row_q, row_d;
   logic [COLS-1:0] stack_q, stack_d;
   logic [3:0]      idx_q, idx_d;
   logic            next_q, next_d;
   logic            over_q, over_d;
   logic            win_q, win_d;
   logic            busy_q, busy_d;

   logic [3:0]      lvl_eff;
   logic [31:0]     dec;
   logic [31:0]     period;
   width_t          w_req, w_stk, spawn_w;
   logic [COLS-1:0] spawn_mask;
   logic [COLS-1:0] ov;
   logic [3:0]      idx_inc;
   logic            tick;
   logic            in_spawn, in_move;

   assign in_spawn = (state_q == S_SPAWN);
   assign in_move  = (state_q == S_MOVE);

   tick_divider u_div (
      .clk       (clk),
      .reset     (reset),
      .clear     (in_spawn || (in_move && bus.drop)),
      .load      (in_spawn),
      .en        (in_move),
      .period_in (period),
      .tick      (tick)
   );

   // Clamped at 2 without ever forming a negative intermediate.
   always_comb begin
      lvl_eff = (bus.level == 4'd0) ? 4'd1 : bus.level;
      dec     = 32'(lvl_eff - 4'd1) * 32'(PERIOD_STEP);
      if (32'(BASE_PERIOD) <= dec + 32'd2)
         period = 32'd2;
      else
         period = 32'(BASE_PERIOD) - dec;
   end

   always_comb begin
      w_req      = clamp_width(bus.num_blocks, COLS);
      w_stk      = popcount(32'(stack_q));
      spawn_w    = (w_req < w_stk) ? w_req : w_stk;
      spawn_mask = ~({COLS{1'b1}} >> spawn_w);
      ov         = row_q & stack_q;
      idx_inc    = idx_q + 4'd1;
   end

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      row_d   = row_q;
      stack_d = stack_q;
      idx_d   = idx_q;
      next_d  = 1'b0;
      over_d  = 1'b0;
      win_d   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.go)
               state_d = S_SPAWN;
         end
         S_SPAWN: begin
            row_d   = spawn_mask;
            dir_d   = DIR_RIGHT;
            state_d = S_MOVE;
         end
         S_MOVE: begin
            if (bus.drop) begin
               state_d = S_LOCK;
            end else if (tick && (row_q != {COLS{1'b1}})) begin
               if (dir_q == DIR_RIGHT) begin
                  if (row_q[0]) begin
                     dir_d = DIR_LEFT;
                     row_d = row_q << 1;
                  end else begin
                     row_d = row_q >> 1;
                  end
               end else begin
                  if (row_q[COLS-1]) begin
                     dir_d = DIR_RIGHT;
                     row_d = row_q >> 1;
                  end else begin
                     row_d = row_q << 1;
                  end
               end
            end
         end
         S_LOCK: begin
            if (ov == '0) begin
               state_d = S_OVER;
               over_d  = 1'b1;
            end else begin
               stack_d = ov;
               row_d   = ov;
               idx_d   = idx_inc;
               next_d  = 1'b1;
               if (idx_inc == 4'(ROWS)) begin
                  state_d = S_WON;
                  win_d   = 1'b1;
               end else begin
                  state_d = S_SPAWN;
               end
            end
         end
         S_OVER, S_WON: begin
            if (bus.go) begin
               stack_d = '1;
               idx_d   = '0;
               state_d = S_SPAWN;
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d == S_SPAWN) ||
               (state_d == S_MOVE)  ||
               (state_d == S_LOCK);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         dir_q   <= DIR_RIGHT;
         row_q   <= '0;
         stack_q <= '1;
         idx_q   <= '0;
         next_q  <= 1'b0;
         over_q  <= 1'b0;
         win_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         row_q   <= row_d;
         stack_q <= stack_d;
         idx_q   <= idx_d;
         next_q  <= next_d;
         over_q  <= over_d;
         win_q   <= win_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.row_mask    = row_q;
   assign bus.stack_mask  = stack_q;
   assign bus.row_index   = idx_q;
   assign bus.next_signal = next_q;
   assign bus.game_over   = over_q;
   assign bus.win         = win_q;
   assign bus.busy        = busy_q;

endmodule

// File: tb/tb_stack_row_controller.sv
// Bench for stack_row_controller: directed game script plus random play,
// compared every cycle against a position/width model of the row.
module tb_stack_row_controller;

   localparam int COLS = 8;
   localparam int ROWS = 4;
   localparam int BASE = 4;
   localparam int STEP = 1;

   localparam int P_IDLE  = 0;
   localparam int P_SPAWN = 1;
   localparam int P_MOVE  = 2;
   localparam int P_LOCK  = 3;
   localparam int P_OVER  = 4;
   localparam int P_WON   = 5;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   stack_row_controller_if #(.COLS(COLS)) bus ();

   stack_row_controller #(
      .COLS        (COLS),
      .ROWS        (ROWS),
      .BASE_PERIOD (BASE),
      .PERIOD_STEP (STEP)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   // model: row is a contiguous segment at 'pos' cells from the left
   int         ph;
   int         pos;
   int         w;
   bit         going_right;
   int         cnt;
   int         per;
   int         idx;
   logic [7:0] mrow;
   logic [7:0] mstack;
   bit         mnext;
   bit         mover;
   bit         mwin;

   function automatic logic [7:0] seg(input int p, input int width);
      logic [7:0] m;
      m = '0;
      for (int i = 0; i < width; i++)
         m[COLS-1-p-i] = 1'b1;
      return m;
   endfunction

   function automatic int ones(input logic [7:0] m);
      int c;
      c = 0;
      for (int i = 0; i < COLS; i++)
         c += int'(m[i]);
      return c;
   endfunction

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_all();
      bit busy_e;
      busy_e = (ph == P_SPAWN) || (ph == P_MOVE) || (ph == P_LOCK);
      check("row_mask",   32'(bus.row_mask),    32'(mrow));
      check("stack_mask", 32'(bus.stack_mask),  32'(mstack));
      check("row_index",  32'(bus.row_index),   32'(idx));
      check("next",       32'(bus.next_signal), 32'(mnext));
      check("game_over",  32'(bus.game_over),   32'(mover));
      check("win",        32'(bus.win),         32'(mwin));
      check("busy",       32'(bus.busy),        32'(busy_e));
   endtask

   task automatic model_reset();
      ph          = P_IDLE;
      pos         = 0;
      w           = 0;
      going_right = 1'b1;
      cnt         = 0;
      per         = BASE;
      idx         = 0;
      mrow        = 8'h00;
      mstack      = 8'hff;
      mnext       = 1'b0;
      mover       = 1'b0;
      mwin        = 1'b0;
   endtask

   task automatic model_clock(input bit g, input bit d,
                              input int lvl, input int nb);
      int lv;
      logic [7:0] ov;
      mnext = 1'b0;
      mover = 1'b0;
      mwin  = 1'b0;
      case (ph)
         P_IDLE: if (g) ph = P_SPAWN;
         P_SPAWN: begin
            lv  = (lvl == 0) ? 1 : lvl;
            per = BASE - (lv - 1) * STEP;
            if (per < 2) per = 2;
            w = (nb == 0) ? 1 : ((nb > COLS) ? COLS : nb);
            if (w > ones(mstack)) w = ones(mstack);
            pos         = 0;
            going_right = 1'b1;
            cnt         = 0;
            mrow        = seg(pos, w);
            ph          = P_MOVE;
         end
         P_MOVE: begin
            if (d) begin
               ph = P_LOCK;
            end else begin
               cnt++;
               if (cnt == per) begin
                  cnt = 0;
                  if (w < COLS) begin
                     if (going_right) begin
                        if (pos + w == COLS) begin
                           going_right = 1'b0;
                           pos--;
                        end else pos++;
                     end else begin
                        if (pos == 0) begin
                           going_right = 1'b1;
                           pos++;
                        end else pos--;
                     end
                     mrow = seg(pos, w);
                  end
               end
            end
         end
         P_LOCK: begin
            ov = mrow & mstack;
            if (ov == 8'h00) begin
               ph    = P_OVER;
               mover = 1'b1;
            end else begin
               mstack = ov;
               mrow   = ov;
               idx++;
               mnext = 1'b1;
               if (idx == ROWS) begin
                  ph   = P_WON;
                  mwin = 1'b1;
               end else ph = P_SPAWN;
            end
         end
         default: begin
            if (g) begin
               mstack = 8'hff;
               idx    = 0;
               ph     = P_SPAWN;
            end
         end
      endcase
   endtask

   task automatic step(input bit g, input bit d);
      bus.go   = g;
      bus.drop = d;
      @(posedge clk);
      model_clock(g, d, int'(bus.level), int'(bus.num_blocks));
      #1;
      check_all();
   endtask

   task automatic run_until(input logic [7:0] target, input bit at_tick,
                            input int limit);
      int n;
      n = 0;
      while (!(ph == P_MOVE && mrow == target &&
               (!at_tick || cnt == per - 1)) && n < limit) begin
         step(1'b0, 1'b0);
         n++;
      end
      total++;
      assert (n < limit) else begin
         bad++;
         $error("FAIL wait_row got=%0d cycles exp=<%0d", n, limit);
      end
   endtask

   initial begin
      bus.go         = 1'b0;
      bus.drop       = 1'b0;
      bus.level      = 4'd1;
      bus.num_blocks = 4'd3;
      reset          = 1'b1;
      model_reset();
      #12;
      check_all();
      check("rst_stack", 32'(bus.stack_mask), 32'hff);
      @(negedge clk);
      reset = 1'b0;

      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      check("spawn_row", 32'(bus.row_mask), 32'he0);
      repeat (4) step(1'b0, 1'b0);
      check("tick1", 32'(bus.row_mask), 32'h70);
      repeat (4) step(1'b0, 1'b0);
      check("tick2", 32'(bus.row_mask), 32'h38);
      check("busy_move", 32'(bus.busy), 32'h1);

      run_until(8'b00000111, 1'b0, 64);
      run_until(8'b00001110, 1'b0, 16);
      run_until(8'b11100000, 1'b0, 64);
      run_until(8'b01110000, 1'b0, 16);
      run_until(8'b00111000, 1'b1, 64);
      step(1'b0, 1'b1);
      check("drop_no_shift", 32'(bus.row_mask), 32'h38);
      step(1'b0, 1'b0);
      check("lock1_stack", 32'(bus.stack_mask), 32'h38);
      check("lock1_next", 32'(bus.next_signal), 32'h1);
      check("lock1_idx", 32'(bus.row_index), 32'h1);
      step(1'b0, 1'b0);
      check("respawn", 32'(bus.row_mask), 32'he0);

      run_until(8'b00001110, 1'b0, 64);
      step(1'b0, 1'b1);
      bus.level = 4'd3;
      step(1'b0, 1'b0);
      check("lock2_stack", 32'(bus.stack_mask), 32'h08);
      step(1'b0, 1'b0);
      check("w1_spawn", 32'(bus.row_mask), 32'h80);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      check("over_pulse", 32'(bus.game_over), 32'h1);
      check("over_row", 32'(bus.row_mask), 32'h80);
      step(1'b0, 1'b0);
      check("over_clear", 32'(bus.game_over), 32'h0);

      step(1'b1, 1'b0);
      check("restart_stack", 32'(bus.stack_mask), 32'hff);
      check("restart_idx", 32'(bus.row_index), 32'h0);
      step(1'b0, 1'b0);
      repeat (2) step(1'b0, 1'b0);
      check("lvl3_period", 32'(bus.row_mask), 32'h70);

      run_until(8'b11100000, 1'b0, 64);
      for (int k = 0; k < ROWS; k++) begin
         run_until(8'b11100000, 1'b0, 16);
         step(1'b0, 1'b1);
         step(1'b0, 1'b0);
      end
      check("win_pulse", 32'(bus.win), 32'h1);
      check("win_next", 32'(bus.next_signal), 32'h1);
      check("win_busy", 32'(bus.busy), 32'h0);
      step(1'b0, 1'b0);
      check("win_clear", 32'(bus.win), 32'h0);

      for (int i = 0; i < 3000; i++) begin
         bit g;
         bit d;
         if ($urandom_range(0, 15) == 0) begin
            bus.level      = 4'($urandom_range(0, 15));
            bus.num_blocks = 4'($urandom_range(0, 15));
         end
         g = ($urandom_range(0, 7) == 0);
         if (ph == P_MOVE)
            d = ($urandom_range(0, 5) == 0);
         else
            d = ($urandom_range(0, 15) == 0);
         step(g, d);
      end

      for (int i = 0; i < 20 && ph != P_MOVE; i++)
         step(ph == P_IDLE || ph == P_OVER || ph == P_WON, 1'b0);
      check("reach_move", 32'(bus.busy), 32'h1);
      step(1'b0, 1'b0);
      #3;
      reset = 1'b1;
      #1;
      model_reset();
      check_all();
      check("midreset_busy", 32'(bus.busy), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      repeat (6) step(1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
